// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bundle between the PC sequencer and the fetch/decode side.
// The master modport is the sequencer; the slave modport is its environment.
interface pc_sequencer_if;
  logic        FetchReq;
  logic        FetchAck;
  logic        Stall;
  logic [31:0] PcOut;
  logic        BranchTaken;
  logic [15:0] BranchOffset;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic        IllOp;
  logic        IrqReq;
  logic [31:0] XpOut;
  logic        TrapTaken;

  modport master (
    output FetchReq, PcOut, XpOut, TrapTaken,
    input  FetchAck, Stall, BranchTaken, BranchOffset,
    input  JumpTaken, JumpTarget, IllOp, IrqReq
  );

  modport slave (
    input  FetchReq, PcOut, XpOut, TrapTaken,
    output FetchAck, Stall, BranchTaken, BranchOffset,
    output JumpTaken, JumpTarget, IllOp, IrqReq
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: req/ack fetch, next-PC select, trap entry.
// Define PC_SEQ_IRQ_EN to honour IrqReq; otherwise interrupts are ignored.
module pc_sequencer #(
  parameter logic [30:0] RESET_VECTOR = 31'h00000000,
  parameter logic [30:0] ILLOP_VECTOR = 31'h00000004,
  parameter logic [30:0] XADR_VECTOR  = 31'h00000008
) (
  input logic           Clock,
  input logic           Reset,
  pc_sequencer_if.master bus
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pcReg;
  logic [31:0] xpReg;
  logic        trapReg;

  logic [30:0] pcInc;
  logic [30:0] brTgt;
  logic [31:0] nextPc;
  logic        trapHit;
  logic        irqHit;
  logic        advance;

  logic unusedJmp;
  assign unusedJmp = ^bus.JumpTarget[1:0];

`ifdef PC_SEQ_IRQ_EN
  assign irqHit = bus.IrqReq & ~pcReg[31];
`else
  logic unusedIrq;
  assign unusedIrq = ^{bus.IrqReq, XADR_VECTOR};
  assign irqHit = 1'b0;
`endif

  always_comb begin
    pcInc   = pcReg[30:0] + 31'd4;
    brTgt   = pcInc + {{13{bus.BranchOffset[15]}}, bus.BranchOffset, 2'b00};
    trapHit = 1'b0;
    nextPc  = {pcReg[31], pcInc};
    if (bus.IllOp) begin
      nextPc  = {1'b1, ILLOP_VECTOR};
      trapHit = 1'b1;
    end else if (irqHit) begin
`ifdef PC_SEQ_IRQ_EN
      nextPc  = {1'b1, XADR_VECTOR};
`endif
      trapHit = 1'b1;
    end else if (bus.JumpTaken) begin
      // Jumps may leave supervisor mode but never enter it.
      nextPc = {pcReg[31] & bus.JumpTarget[31], bus.JumpTarget[30:2], 2'b00};
    end else if (bus.BranchTaken) begin
      nextPc = {pcReg[31], brTgt};
    end
  end

  always_comb begin
    advance = 1'b0;
    unique case (state)
      REQ:     advance = bus.FetchAck & ~bus.Stall;
      HOLD:    advance = ~bus.Stall;
      default: advance = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= BOOT;
      pcReg   <= {1'b1, RESET_VECTOR};
      xpReg   <= 32'd0;
      trapReg <= 1'b0;
    end else begin
      trapReg <= 1'b0;
      unique case (state)
        BOOT: state <= REQ;
        REQ:  if (bus.FetchAck && bus.Stall) state <= HOLD;
        HOLD: if (!bus.Stall) state <= REQ;
        default: state <= BOOT;
      endcase
      if (advance) begin
        pcReg <= nextPc;
        if (trapHit) begin
          xpReg   <= {pcReg[31], pcInc};
          trapReg <= 1'b1;
        end
      end
    end
  end

  assign bus.FetchReq  = (state == REQ);
  assign bus.PcOut     = pcReg;
  assign bus.XpOut     = xpReg;
  assign bus.TrapTaken = trapReg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed walk plus random traffic.
// Reference model works on fetch transactions and next-PC rules.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer dut (.Clock(clk), .Reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [63:0] fetchQ[$];
  logic [31:0] trapQ[$];
  bit monOn = 1'b0;

  logic [31:0] mPc;
  logic [31:0] mXp;
  bit mBoot = 1'b0;
  bit mHold = 1'b0;
  bit mValid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] calcNext(
    input logic [31:0] pc, input bit br, input logic [15:0] off,
    input bit jp, input logic [31:0] tgt, input bit ill, input bit irq);
    logic [30:0] inc;
    logic signed [31:0] so;
    logic [30:0] brT;
    bit irqOk;
    inc = pc[30:0] + 31'd4;
    so = 32'($signed(off)) * 4;
    brT = inc + so[30:0];
`ifdef PC_SEQ_IRQ_EN
    irqOk = irq && !pc[31];
`else
    irqOk = 1'b0;
    if (irq) irqOk = 1'b0;
`endif
    if (ill) return {1'b1, 32'h80000004};
    if (irqOk) return {1'b1, 32'h80000008};
    if (jp) return {1'b0, pc[31] & tgt[31], tgt[30:2], 2'b00};
    if (br) return {1'b0, pc[31], brT};
    return {1'b0, pc[31], inc};
  endfunction

  task automatic cyc(input bit r, input bit ack, input bit st,
                     input bit br, input logic [15:0] off, input bit jp,
                     input logic [31:0] tgt, input bit ill, input bit irq);
    logic [32:0] n;
    rst = r;
    bus.FetchAck = ack;
    bus.Stall = st;
    bus.BranchTaken = br;
    bus.BranchOffset = off;
    bus.JumpTaken = jp;
    bus.JumpTarget = tgt;
    bus.IllOp = ill;
    bus.IrqReq = irq;
    if (mValid && !mBoot && !mHold && ack) fetchQ.push_back({mPc, mXp});
    @(posedge clk);
    n = calcNext(mPc, br, off, jp, tgt, ill, irq);
    if (r) begin
      mPc = 32'h80000000;
      mXp = 32'd0;
      mBoot = 1'b1;
      mHold = 1'b0;
      mValid = 1'b1;
    end else if (!mValid) begin
      mValid = 1'b0;
    end else if (mBoot) begin
      mBoot = 1'b0;
    end else if (mHold || ack) begin
      if (st) begin
        mHold = 1'b1;
      end else begin
        mHold = 1'b0;
        if (n[32]) begin
          mXp = {mPc[31], mPc[30:0] + 31'd4};
          trapQ.push_back(mXp);
        end
        mPc = n[31:0];
      end
    end
    #1;
  endtask

  task automatic seq();
    cyc(0, 1, 0, 0, 16'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t);
    cyc(0, 1, 0, 0, 16'h0, 1, t, 0, 0);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (bus.FetchReq === 1'b1 && bus.FetchAck) begin
        if (fetchQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch: unexpected fetch of %h", bus.PcOut);
        end else begin
          logic [63:0] e;
          e = fetchQ.pop_front();
          chk("fetchPc", bus.PcOut, e[63:32]);
          chk("fetchXp", bus.XpOut, e[31:0]);
        end
      end else if (fetchQ.size() != 0) begin
        void'(fetchQ.pop_front());
        chk("fetchReq", {31'd0, bus.FetchReq}, 32'd1);
      end
      if (bus.TrapTaken === 1'b1) begin
        if (trapQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trapPulse: got TrapTaken=1 expected 0");
        end else begin
          chk("trapXp", bus.XpOut, trapQ.pop_front());
        end
      end else if (trapQ.size() != 0) begin
        void'(trapQ.pop_front());
        chk("trapPulse", {31'd0, bus.TrapTaken}, 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.FetchAck = 1'b0;
    bus.Stall = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchOffset = 16'h0;
    bus.JumpTaken = 1'b0;
    bus.JumpTarget = 32'h0;
    bus.IllOp = 1'b0;
    bus.IrqReq = 1'b0;

    cyc(1, 1, 0, 0, 16'h0, 0, 32'h0, 0, 0);
    monOn = 1'b1;
    chk("rstPc", bus.PcOut, 32'h80000000);
    chk("rstXp", bus.XpOut, 32'h0);
    chk("rstReq", {31'd0, bus.FetchReq}, 32'd0);
    chk("rstTrap", {31'd0, bus.TrapTaken}, 32'd0);
    cyc(1, 1, 0, 0, 16'h0, 0, 32'h0, 0, 0);
    chk("bootReq", {31'd0, bus.FetchReq}, 32'd0);
    seq();
    chk("firstReq", {31'd0, bus.FetchReq}, 32'd1);
    seq();
    seq();
    chk("seqPc", bus.PcOut, 32'h80000008);

    jmp(32'hFFFFFFFC);
    seq();
    chk("wrapSup", bus.PcOut, 32'h80000000);
    jmp(32'h7FFFFFFC);
    chk("jmpUser", bus.PcOut, 32'h7FFFFFFC);
    seq();
    chk("wrapUser", bus.PcOut, 32'h00000000);

    jmp(32'h00000100);
    cyc(0, 1, 0, 1, 16'hFFFF, 0, 32'h0, 0, 0);
    chk("brNeg", bus.PcOut, 32'h00000100);
    cyc(0, 1, 0, 1, 16'h0010, 0, 32'h0, 0, 0);
    chk("brPos", bus.PcOut, 32'h00000144);

    cyc(0, 1, 0, 0, 16'h0, 0, 32'h0, 1, 0);
    chk("illPc", bus.PcOut, 32'h80000004);
    chk("illXp", bus.XpOut, 32'h00000148);
    chk("illPulse", {31'd0, bus.TrapTaken}, 32'd1);
    seq();
    chk("pulseEnd", {31'd0, bus.TrapTaken}, 32'd0);

    jmp(32'h80000010);
    jmp(32'h80000203);
    chk("jmpSup", bus.PcOut, 32'h80000200);
    jmp(32'h00000010);
    jmp(32'h80000203);
    chk("jmpNoSup", bus.PcOut, 32'h00000200);

    jmp(32'h00000020);
    cyc(0, 1, 0, 0, 16'h0, 1, 32'h00000300, 0, 1);
`ifdef PC_SEQ_IRQ_EN
    chk("irqPc", bus.PcOut, 32'h80000008);
    chk("irqXp", bus.XpOut, 32'h00000024);
    chk("irqPulse", {31'd0, bus.TrapTaken}, 32'd1);
`else
    chk("irqOff", bus.PcOut, 32'h00000300);
    chk("irqOffPulse", {31'd0, bus.TrapTaken}, 32'd0);
`endif
    jmp(32'h00000020);
    cyc(0, 1, 0, 0, 16'h0, 1, 32'h00000300, 1, 1);
    chk("illIrqPc", bus.PcOut, 32'h80000004);
    chk("illIrqXp", bus.XpOut, 32'h00000024);
    jmp(32'h80000020);
    cyc(0, 1, 0, 0, 16'h0, 0, 32'h0, 0, 1);
    chk("irqMask", bus.PcOut, 32'h80000024);

    jmp(32'h00000040);
    cyc(0, 1, 1, 0, 16'h0, 0, 32'h0, 0, 0);
    chk("holdPc", bus.PcOut, 32'h00000040);
    chk("holdReq", {31'd0, bus.FetchReq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, i[0], 16'h0010, 0, 32'h0, 0, 0);
      chk("holdStall", bus.PcOut, 32'h00000040);
    end
    cyc(0, 0, 0, 0, 16'h0, 0, 32'h0, 0, 0);
    chk("holdExit", bus.PcOut, 32'h00000044);
    chk("holdExitReq", {31'd0, bus.FetchReq}, 32'd1);
    cyc(0, 1, 1, 0, 16'h0, 0, 32'h0, 0, 0);
    cyc(1, 0, 1, 1, 16'h0010, 0, 32'h0, 0, 0);
    chk("holdRst", bus.PcOut, 32'h80000000);
    chk("holdRstReq", {31'd0, bus.FetchReq}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0,
          16'($urandom),
          $urandom_range(0, 7) == 0,
          $urandom,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 5) == 0);
    end
    cyc(0, 0, 1, 0, 16'h0, 0, 32'h0, 0, 0);
    @(negedge clk);
    #1;
    chk("fetchDrain", fetchQ.size(), 32'd0);
    chk("trapDrain", trapQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
